bomb_controller: RTL and testbench



---
 rtl/bomb_controller.sv | 166 ++++++++++++++++
 tb/tb_bomb_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bomb_controller.sv
// Single-bomb controller: snaps the drop point to the tile grid and sequences fuse, blast and cooldown in frames.
// Optional macro BOMB_REMOTE_EN adds remote_detonate / remote_ready.
module bomb_controller #(
    parameter int X_ORIGIN        = 15,
    parameter int Y_ORIGIN        = 48,
    parameter int COLS            = 19,
    parameter int ROWS            = 13,
    parameter int FUSE_FRAMES     = 90,
    parameter int BLAST_FRAMES    = 15,
    parameter int COOLDOWN_FRAMES = 4
) (
    input  logic               clk,
    input  logic               reset,
`ifdef BOMB_REMOTE_EN
    input  logic               remote_detonate,
    output logic               remote_ready,
`endif
    input  logic               startOfFrame,
    input  logic               drop_bomb,
    input  logic               chain_trigger,
    input  logic signed [10:0] playerTopLeftX,
    input  logic signed [10:0] playerTopLeftY,
    output logic signed [10:0] bombTopLeftX,
    output logic signed [10:0] bombTopLeftY,
    output logic        [4:0]  bomb_col,
    output logic        [3:0]  bomb_row,
    output logic               bomb_active,
    output logic               bomb_exploding,
    output logic               explode_start,
    output logic        [7:0]  fuse_left
);

    typedef enum logic [1:0] {IDLE_ST, ARMED_ST, EXPLODE_ST, COOLDOWN_ST} state_t;

    state_t      state_q, state_d;
    logic        drop_prev_q;
    logic        drop_req;
    logic        detonate;
    logic        start_q, start_d;
    logic [7:0]  fuse_q, fuse_d, blast_q, blast_d, cool_q, cool_d;
    logic [4:0]  col_q, col_d;
    logic [3:0]  row_q, row_d;
    logic [10:0] x_q, x_d, y_q, y_d;

    // Tile snap: offset to the player's centre, clamp negatives to 0 and overflow to the last tile.
    logic [11:0] off_x, off_y;
    logic [6:0]  tile_x, tile_y;
    logic [5:0]  col_raw, row_raw;
    logic [4:0]  snap_col;
    logic [3:0]  snap_row;

    assign off_x    = {playerTopLeftX[10], playerTopLeftX} + 12'd16 - 12'(X_ORIGIN);
    assign off_y    = {playerTopLeftY[10], playerTopLeftY} + 12'd16 - 12'(Y_ORIGIN);
    assign tile_x   = 7'(off_x >> 5);
    assign tile_y   = 7'(off_y >> 5);
    assign col_raw  = tile_x[6] ? 6'd0 : tile_x[5:0];
    assign row_raw  = tile_y[6] ? 6'd0 : tile_y[5:0];
    assign snap_col = (col_raw > 6'(COLS - 1)) ? 5'(COLS - 1) : col_raw[4:0];
    assign snap_row = (row_raw > 6'(ROWS - 1)) ? 4'(ROWS - 1) : row_raw[3:0];

    assign drop_req = drop_bomb & ~drop_prev_q;

`ifdef BOMB_REMOTE_EN
    logic remote_prev_q;
    always_ff @(posedge clk) begin
        if (reset) remote_prev_q <= 1'b0;
        else       remote_prev_q <= remote_detonate;
    end
    assign detonate     = chain_trigger | (remote_detonate & ~remote_prev_q);
    assign remote_ready = (state_q == ARMED_ST);
`else
    assign detonate = chain_trigger;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE_ST;
            drop_prev_q <= 1'b0;
            start_q     <= 1'b0;
            fuse_q      <= '0;
            blast_q     <= '0;
            cool_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            drop_prev_q <= drop_bomb;
            start_q     <= start_d;
            fuse_q      <= fuse_d;
            blast_q     <= blast_d;
            cool_q      <= cool_d;
            col_q       <= col_d;
            row_q       <= row_d;
            x_q         <= x_d;
            y_q         <= y_d;
        end
    end

    always_comb begin
        // NOTE: every next-state value gets a default first so no latch can be inferred.
        state_d = state_q;
        start_d = 1'b0;
        fuse_d  = fuse_q;
        blast_d = blast_q;
        cool_d  = cool_q;
        col_d   = col_q;
        row_d   = row_q;
        x_d     = x_q;
        y_d     = y_q;
        unique case (state_q)
            IDLE_ST: begin
                if (drop_req) begin
                    col_d   = snap_col;
                    row_d   = snap_row;
                    x_d     = 11'(X_ORIGIN) + {1'b0, snap_col, 5'b0};
                    y_d     = 11'(Y_ORIGIN) + {2'b0, snap_row, 5'b0};
                    fuse_d  = 8'(FUSE_FRAMES);
                    state_d = ARMED_ST;
                end
            end
            ARMED_ST: begin
                if (detonate || (startOfFrame && fuse_q == 8'd1)) begin
                    state_d = EXPLODE_ST;
                    start_d = 1'b1;
                    fuse_d  = '0;
                    blast_d = 8'(BLAST_FRAMES);
                end else if (startOfFrame) begin
                    fuse_d = fuse_q - 8'd1;
                end
            end
            EXPLODE_ST: begin
                if (startOfFrame) begin
                    if (blast_q == 8'd1) begin
                        state_d = COOLDOWN_ST;
                        cool_d  = 8'(COOLDOWN_FRAMES);
                    end else begin
                        blast_d = blast_q - 8'd1;
                    end
                end
            end
            COOLDOWN_ST: begin
                // A zero-length cooldown loads 0 and leaves on the following cycle.
                if (cool_q == 8'd0 || (startOfFrame && cool_q == 8'd1)) begin
                    state_d = IDLE_ST;
                    cool_d  = '0;
                end else if (startOfFrame) begin
                    cool_d = cool_q - 8'd1;
                end
            end
            default: state_d = IDLE_ST;
        endcase
    end

    assign bombTopLeftX   = $signed(x_q);
    assign bombTopLeftY   = $signed(y_q);
    assign bomb_col       = col_q;
    assign bomb_row       = row_q;
    assign bomb_active    = (state_q == ARMED_ST);
    assign bomb_exploding = (state_q == EXPLODE_ST);
    assign explode_start  = start_q;
    assign fuse_left      = (state_q == ARMED_ST) ? fuse_q : 8'd0;

endmodule

// File: tb/tb_bomb_controller.sv
// Self-checking bench for bomb_controller: directed scenarios plus random stimulus against a frame-counting model.
module tb_bomb_controller;

    localparam int FUSE  = 90;
    localparam int BLAST = 15;
    localparam int COOL  = 4;

    logic               clk = 1'b0;
    logic               reset, sof, drop, chain;
    logic signed [10:0] px, py;
    logic signed [10:0] bomb_x, bomb_y;
    logic        [4:0]  bomb_col;
    logic        [3:0]  bomb_row;
    logic               bomb_active, bomb_exploding, explode_start;
    logic        [7:0]  fuse_left;

    int n_tests = 0;
    int n_fail  = 0;
    int start_pulses = 0;

    // Reference model: phase plus number of frame pulses seen in that phase.
    int m_phase;    // 0 idle, 1 armed, 2 exploding, 3 cooldown
    int m_frames;
    int m_col, m_row, m_x, m_y, m_start;
    bit m_prev_drop;

    bomb_controller dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (sof),
        .drop_bomb      (drop),
        .chain_trigger  (chain),
        .playerTopLeftX (px),
        .playerTopLeftY (py),
        .bombTopLeftX   (bomb_x),
        .bombTopLeftY   (bomb_y),
        .bomb_col       (bomb_col),
        .bomb_row       (bomb_row),
        .bomb_active    (bomb_active),
        .bomb_exploding (bomb_exploding),
        .explode_start  (explode_start),
        .fuse_left      (fuse_left)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int snap(input int pos, input int origin, input int count);
        int off = pos + 16 - origin;
        int t   = (off < 0) ? 0 : off / 32;
        return (t > count - 1) ? count - 1 : t;
    endfunction

    task automatic model_edge();
        bit req;
        m_start = 0;
        if (reset) begin
            m_phase = 0; m_frames = 0; m_prev_drop = 0;
            m_col = 0; m_row = 0; m_x = 0; m_y = 0;
        end else begin
            req = drop && !m_prev_drop;
            m_prev_drop = drop;
            case (m_phase)
                0: if (req) begin
                    m_col = snap(int'(px), 15, 19);
                    m_row = snap(int'(py), 48, 13);
                    m_x = 15 + 32 * m_col;
                    m_y = 48 + 32 * m_row;
                    m_phase = 1; m_frames = 0;
                end
                1: begin
                    if (sof) m_frames++;
                    if (chain || m_frames == FUSE) begin
                        m_phase = 2; m_frames = 0; m_start = 1;
                    end
                end
                2: if (sof) begin
                    m_frames++;
                    if (m_frames == BLAST) begin m_phase = 3; m_frames = 0; end
                end
                default: if (sof) begin
                    m_frames++;
                    if (m_frames == COOL) begin m_phase = 0; m_frames = 0; end
                end
            endcase
        end
    endtask

    task automatic compare_all();
        check("active",    bomb_active,    m_phase == 1);
        check("exploding", bomb_exploding, m_phase == 2);
        check("start",     explode_start,  m_start);
        check("fuse_left", fuse_left,      (m_phase == 1) ? FUSE - m_frames : 0);
        check("col",       bomb_col,       m_col);
        check("row",       bomb_row,       m_row);
        check("x",         bomb_x,         m_x);
        check("y",         bomb_y,         m_y);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
        if (explode_start) start_pulses++;
    endtask

    task automatic frame();
        sof = 1'b1; step();
        sof = 1'b0; step();
    endtask

    task automatic press(input int x, input int y);
        px = 11'(x); py = 11'(y);
        drop = 1'b1; step();
        drop = 1'b0;
    endtask

    initial begin
        int guard, n;
        reset = 1'b1; sof = 1'b0; drop = 1'b0; chain = 1'b0; px = '0; py = '0;
        step(); step();
        check("reset_fuse", fuse_left, 0);
        check("reset_x", bomb_x, 0);
        reset = 1'b0;
        step();

        // Drop at the grid origin; fuse runs the full 90 frames.
        press(15, 48);
        check("t1_col", bomb_col, 0);
        check("t1_row", bomb_row, 0);
        check("t1_x", bomb_x, 15);
        check("t1_y", bomb_y, 48);
        check("t1_active", bomb_active, 1);
        check("t1_fuse", fuse_left, 90);
        start_pulses = 0;
        for (int i = 0; i < FUSE - 1; i++) frame();
        check("t1_pre_explode", bomb_exploding, 0);
        check("t1_fuse_last", fuse_left, 1);
        sof = 1'b1; step();
        check("t1_start_pulse", explode_start, 1);
        check("t1_fuse_zero", fuse_left, 0);
        sof = 1'b0; step();
        check("t1_start_once", explode_start, 0);
        n = 0; guard = 0;
        while (bomb_exploding && guard < 100) begin frame(); n++; guard++; end
        check("t1_blast_frames", n, BLAST);
        check("t1_start_count", start_pulses, 1);
        for (int i = 0; i < COOL - 1; i++) frame();
        press(100, 200);
        check("t1_drop_in_cooldown", bomb_active, 0);
        frame();

        // Centre-of-field and clamped drops.
        press(100, 200);
        check("t2_col", bomb_col, 3);
        check("t2_row", bomb_row, 5);
        check("t2_x", bomb_x, 111);
        check("t2_y", bomb_y, 208);
        press(620, 470);
        check("t2_ignored_col", bomb_col, 3);
        reset = 1'b1; step(); reset = 1'b0; step();
        press(620, 470);
        check("t3_col", bomb_col, 18);
        check("t3_row", bomb_row, 12);
        check("t3_x", bomb_x, 591);
        check("t3_y", bomb_y, 432);
        reset = 1'b1; step(); reset = 1'b0; step();

        // Key held for 200 frames gives exactly one bomb.
        px = 11'(200); py = 11'(100); drop = 1'b1;
        start_pulses = 0;
        for (int i = 0; i < 200; i++) frame();
        check("held_one_bomb", start_pulses, 1);
        drop = 1'b0; step();
        press(300, 300);
        check("held_rearm", bomb_active, 1);

        // Chain trigger coincident with a frame pulse at fuse_left 40.
        for (int i = 0; i < 50; i++) frame();
        check("chain_fuse40", fuse_left, 40);
        start_pulses = 0;
        sof = 1'b1; chain = 1'b1; step();
        sof = 1'b0; chain = 1'b0;
        check("chain_exploding", bomb_exploding, 1);
        check("chain_start", explode_start, 1);
        check("chain_fuse0", fuse_left, 0);
        chain = 1'b1; frame(); frame(); chain = 1'b0;
        check("chain_start_count", start_pulses, 1);

        // Reset in the middle of the blast.
        reset = 1'b1; step(); reset = 1'b0;
        check("rst_exploding", bomb_exploding, 0);
        check("rst_start", explode_start, 0);
        check("rst_col", bomb_col, 0);
        press(40, 80);
        check("rst_rearm", bomb_active, 1);

        // Random stimulus against the model.
        for (int i = 0; i < 12000; i++) begin
            reset = ($urandom_range(0, 1499) == 0);
            sof   = ($urandom_range(0, 1) == 0);
            chain = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 14) == 0) drop = ~drop;
            if ($urandom_range(0, 7) == 0) begin
                px = 11'($urandom_range(0, 2047));
                py = 11'($urandom_range(0, 2047));
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
